// File: rtl/center_of_mass.sv
// center_of_mass: per-frame centroid of masked pixels, using saturating accumulators
// and two parallel 32-cycle restoring dividers.
module center_of_mass #(
  parameter int HCOUNT_W = 11,
  parameter int VCOUNT_W = 10
) (
  input  logic                clk_in,
  input  logic                rst_n_in,
  input  logic [HCOUNT_W-1:0] x_in,
  input  logic [VCOUNT_W-1:0] y_in,
  input  logic                valid_in,
  input  logic                mask_in,
  input  logic                tabulate_in,
  output logic [HCOUNT_W-1:0] x_out,
  output logic [VCOUNT_W-1:0] y_out,
  output logic                valid_out,
  output logic                busy_out
);
  typedef enum logic [1:0] {IDLE_ACCUM, DIVIDE, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] sx_q, sy_q, sx_n, sy_n, sx_d, sy_d;
  logic [19:0] cnt_q, cnt_n, cnt_d, den_q;
  logic [32:0] sx_add, sy_add;
  logic [20:0] cnt_add;
  logic [51:0] divx_q, divy_q;
  logic [4:0]  step_q;
  logic [HCOUNT_W-1:0] x_q;
  logic [VCOUNT_W-1:0] y_q;
  logic        valid_q, pix, take;
  logic        unused_div;

  // One restoring step on {remainder[19:0], dividend/quotient[31:0]}.
  function automatic logic [51:0] div_step(input logic [51:0] rq, input logic [19:0] d);
    logic [20:0] t, s;
    t = {rq[51:32], rq[31]};
    s = t - {1'b0, d};
    div_step = s[20] ? {t[19:0], rq[30:0], 1'b0} : {s[19:0], rq[30:0], 1'b1};
  endfunction

  assign pix     = valid_in & mask_in;
  assign take    = (state_q == IDLE_ACCUM) & tabulate_in;
  assign sx_add  = {1'b0, sx_q} + {{(33-HCOUNT_W){1'b0}}, x_in};
  assign sy_add  = {1'b0, sy_q} + {{(33-VCOUNT_W){1'b0}}, y_in};
  assign cnt_add = {1'b0, cnt_q} + 21'd1;

  // sx_n/sy_n/cnt_n include the current pixel; they feed both the snapshot and the accumulators.
  always_comb begin
    sx_n  = !pix ? sx_q  : sx_add[32]  ? '1 : sx_add[31:0];
    sy_n  = !pix ? sy_q  : sy_add[32]  ? '1 : sy_add[31:0];
    cnt_n = !pix ? cnt_q : cnt_add[20] ? '1 : cnt_add[19:0];
    sx_d  = take ? '0 : sx_n;
    sy_d  = take ? '0 : sy_n;
    cnt_d = take ? '0 : cnt_n;
  end

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) state_q <= IDLE_ACCUM;
    else state_q <= state_d;

  always_comb begin
    state_d = state_q;
    if (state_q == IDLE_ACCUM) state_d = (take && |cnt_n) ? DIVIDE : IDLE_ACCUM;
    else if (state_q == DIVIDE) state_d = (step_q == 5'd31) ? DONE : DIVIDE;
    else state_d = IDLE_ACCUM;
  end

  always_comb busy_out = (state_q != IDLE_ACCUM);

  always_ff @(posedge clk_in or negedge rst_n_in)
    if (!rst_n_in) begin
      sx_q    <= '0;
      sy_q    <= '0;
      cnt_q   <= '0;
      den_q   <= '0;
      divx_q  <= '0;
      divy_q  <= '0;
      step_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      sx_q    <= sx_d;
      sy_q    <= sy_d;
      cnt_q   <= cnt_d;
      valid_q <= (state_q == DONE);
      if (take) begin
        divx_q <= {20'd0, sx_n};
        divy_q <= {20'd0, sy_n};
        den_q  <= cnt_n;
        step_q <= '0;
      end else if (state_q == DIVIDE) begin
        divx_q <= div_step(divx_q, den_q);
        divy_q <= div_step(divy_q, den_q);
        step_q <= step_q + 5'd1;
      end
      if (state_q == DONE) begin
        x_q <= divx_q[HCOUNT_W-1:0];
        y_q <= divy_q[VCOUNT_W-1:0];
      end
    end

  assign unused_div = ^{divx_q[51:HCOUNT_W], divy_q[51:VCOUNT_W]};
  assign x_out      = x_q;
  assign y_out      = y_q;
  assign valid_out  = valid_q;
endmodule
